// File: rtl/neuron_mem_loader_if.sv
// Stream-in and memory-write bus between a word source and the neuron x/w memory loader.
// A word moves on a cycle where in_valid and in_ready are both high; once raised, in_valid holds its word until that cycle.
interface neuron_mem_loader_if #(
  parameter int N = 16,
  parameter int Q = 4,
  parameter int d = 2
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         x_write;
  logic         w_write;
  logic [Q-1:0] wr_addr;
  logic [d-1:0] wr_index;
  logic [N-1:0] wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, x_write, w_write, wr_addr, wr_index, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, x_write, w_write, wr_addr, wr_index, wr_data
  );
endinterface

// File: rtl/neuron_mem_loader.sv
// Loads a dimension-fastest word stream into the x or w memory of the neuron datapath,
// flags framing errors and pulses done when the requested vectors are written.
module neuron_mem_loader #(
  parameter int N = 16,
  parameter int Q = 4,
  parameter int d = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sel,
  input  logic [Q-1:0]        base_addr,
  input  logic [Q:0]          num_vec,
  neuron_mem_loader_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [Q:0]   VEC_ONE = 1;
  localparam logic [d-1:0] IDX_ONE = 1;
  localparam logic [d-1:0] IDX_MAX = '1;

  state_t       state, state_n;
  logic         ready;
  logic         xfer;
  logic         last_word;
  logic         sel_r;
  logic [Q-1:0] base_r;
  logic [Q:0]   num_r;
  logic [Q:0]   vec;
  logic [d-1:0] idx;
  logic         x_write_q, w_write_q;
  logic [Q-1:0] wr_addr_q;
  logic [d-1:0] wr_index_q;
  logic [N-1:0] wr_data_q;
  logic         err_q;

  assign xfer      = ready & bus.in_valid;
  assign last_word = (vec == num_r - VEC_ONE) && (idx == IDX_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = (num_vec == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: if (xfer && (bus.in_last || last_word)) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      ST_LOAD: begin
        busy  = 1'b1;
        ready = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Write strobes last one cycle; address/index/data hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_r      <= 1'b0;
      base_r     <= '0;
      num_r      <= '0;
      vec        <= '0;
      idx        <= '0;
      x_write_q  <= 1'b0;
      w_write_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      x_write_q <= 1'b0;
      w_write_q <= 1'b0;
      if (state == ST_IDLE && start) begin
        sel_r  <= sel;
        base_r <= base_addr;
        num_r  <= num_vec;
        vec    <= '0;
        idx    <= '0;
        err_q  <= 1'b0;
      end else if (xfer) begin
        x_write_q  <= ~sel_r;
        w_write_q  <= sel_r;
        wr_addr_q  <= base_r + vec[Q-1:0];
        wr_index_q <= idx;
        wr_data_q  <= bus.in_data;
        idx        <= idx + IDX_ONE;
        if (idx == IDX_MAX) vec <= vec + VEC_ONE;
        // in_last must coincide exactly with the final word of the frame
        if (bus.in_last != last_word) err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.x_write  = x_write_q;
  assign bus.w_write  = w_write_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_index = wr_index_q;
  assign bus.wr_data  = wr_data_q;
  assign err          = err_q;
  assign state_dbg    = state;

endmodule
